// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Shares the single user port of the sdram controller between a
//               high-priority streaming requester (port A) and a general
//               requester (port B). One single-word access is granted at a
//               time. Read data comes back with a one-cycle acknowledge, and a
//               watchdog flags a hung controller.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   AW    - word address width
//   DW    - data width
//   TMO_W - watchdog counter width; timeout on the (2^TMO_W-1)th WAIT cycle
// Ports:
//   clock, reset             - sole clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata - port A level request and command
//   a_ack, a_gnt              - port A completion strobe and ownership flag
//   b_*                       - same as port A, for port B
//   rdata                     - read data, valid while either ack is high
//   ctl_ready                 - controller initialised and idle
//   ctl_req/ctl_we/ctl_addr/ctl_wdata - registered command to the controller
//   ctl_done, ctl_rdata       - controller completion strobe and read data
//   timeout                   - sticky watchdog error flag
// Configuration macro:
//   SDRAM_ARB_RR_EN - defined: round-robin between A and B;
//                     undefined: fixed priority, A always beats B.
// ============================================================================
module sdram_arbiter #(
    parameter int unsigned AW    = 24,
    parameter int unsigned DW    = 16,
    parameter int unsigned TMO_W = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic          a_gnt,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_gnt,
    output logic [DW-1:0] rdata,
    input  logic          ctl_ready,
    output logic          ctl_req,
    output logic          ctl_we,
    output logic [AW-1:0] ctl_addr,
    output logic [DW-1:0] ctl_wdata,
    input  logic          ctl_done,
    input  logic [DW-1:0] ctl_rdata,
    output logic          timeout
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ISSUE = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_DONE  = 3'd3;
    localparam logic [2:0] c_REST  = 3'd4;

    localparam logic [TMO_W-1:0] c_WDOG_ONE = TMO_W'(1);
    localparam logic [TMO_W-1:0] c_WDOG_MAX = '1;

    logic [2:0]       r_state;
    logic [TMO_W-1:0] r_wdog;
    logic [TMO_W-1:0] w_wdog_inc;
    logic             w_grant_b;

`ifdef SDRAM_ARB_RR_EN
    // Set when B should win the next simultaneous request (A granted last).
    logic r_rr_b;

    always_comb begin
        w_grant_b = b_req && (!a_req || r_rr_b);
    end
`else
    always_comb begin
        w_grant_b = b_req && !a_req;
    end
`endif

    // The counter holds the number of completed WAIT cycles, so the
    // incremented value reaches all-ones on the (2^TMO_W-1)th WAIT cycle.
    always_comb begin
        w_wdog_inc = r_wdog + c_WDOG_ONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_wdog    <= '0;
            ctl_req   <= 1'b0;
            ctl_we    <= 1'b0;
            ctl_addr  <= '0;
            ctl_wdata <= '0;
            rdata     <= '0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            timeout   <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            r_rr_b    <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (ctl_ready && (a_req || b_req)) begin
                        ctl_req <= 1'b1;
                        r_wdog  <= '0;
                        r_state <= c_ISSUE;
                        if (w_grant_b) begin
                            b_gnt     <= 1'b1;
                            ctl_we    <= b_we;
                            ctl_addr  <= b_addr;
                            ctl_wdata <= b_wdata;
`ifdef SDRAM_ARB_RR_EN
                            r_rr_b    <= 1'b0;
`endif
                        end else begin
                            a_gnt     <= 1'b1;
                            ctl_we    <= a_we;
                            ctl_addr  <= a_addr;
                            ctl_wdata <= a_wdata;
`ifdef SDRAM_ARB_RR_EN
                            r_rr_b    <= 1'b1;
`endif
                        end
                    end
                end

                c_ISSUE: begin
                    ctl_req <= 1'b0;
                    r_state <= c_WAIT;
                end

                c_WAIT: begin
                    r_wdog <= w_wdog_inc;
                    // A completion in the saturating cycle takes precedence.
                    if (ctl_done) begin
                        rdata   <= ctl_rdata;
                        a_ack   <= a_gnt;
                        b_ack   <= b_gnt;
                        r_state <= c_DONE;
                    end else if (w_wdog_inc == c_WDOG_MAX) begin
                        timeout <= 1'b1;
                        rdata   <= '0;
                        a_ack   <= a_gnt;
                        b_ack   <= b_gnt;
                        r_state <= c_DONE;
                    end
                end

                c_DONE: begin
                    a_ack   <= 1'b0;
                    b_ack   <= 1'b0;
                    r_wdog  <= '0;
                    r_state <= c_REST;
                end

                c_REST: begin
                    // Dead cycle lets the requester drop req before IDLE.
                    a_gnt   <= 1'b0;
                    b_gnt   <= 1'b0;
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Scoreboard bench for sdram_arbiter. Directed stimulus pushes
//               the expected acknowledge into a queue; a monitor pops and
//               compares on every ack. A small controller model answers
//               ctl_req after a programmable number of WAIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int AW    = 24;
    localparam int DW    = 16;
    localparam int TMO_W = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_ack, a_gnt;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_ack, b_gnt;
    logic [DW-1:0] rdata;
    logic          ctl_ready = 1'b0;
    logic          ctl_req, ctl_we;
    logic [AW-1:0] ctl_addr;
    logic [DW-1:0] ctl_wdata;
    logic          ctl_done;
    logic [DW-1:0] ctl_rdata;
    logic          timeout;

    // Controller model drives m_*, the stimulus may inject a stray s_* pulse.
    logic          m_done = 1'b0, s_done = 1'b0;
    logic [DW-1:0] m_rdata = '0, s_rdata = '0;
    assign ctl_done  = m_done | s_done;
    assign ctl_rdata = m_done ? m_rdata : s_rdata;

    sdram_arbiter #(.AW(AW), .DW(DW), .TMO_W(TMO_W)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_gnt(a_gnt),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_gnt(b_gnt),
        .rdata(rdata),
        .ctl_ready(ctl_ready), .ctl_req(ctl_req), .ctl_we(ctl_we),
        .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
        .ctl_done(ctl_done), .ctl_rdata(ctl_rdata),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          port_b;
        logic [15:0] data;
        bit          tmo;
        bit          wdog;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_acks = 0;
    int          n_ctlreq = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [15:0] resp = '0;
    int          req_cyc = 0;
    int          done_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit pb, input logic [15:0] d,
                            input bit tmo, input bit wd);
        exp_t e;
        e.port_b = pb;
        e.data   = d;
        e.tmo    = tmo;
        e.wdog   = wd;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string name);
        check(name, {1'b0, ctl_req, ctl_we, a_ack, b_ack, a_gnt, b_gnt,
                     timeout, ctl_addr, ctl_wdata, rdata}, 64'd0);
    endtask

    task automatic wait_acks(input int target, input int budget);
        int k = 0;
        while (n_acks < target && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("ack_wait_bound", 64'(n_acks >= target), 64'd1);
    endtask

    task automatic wait_ctl_req(input int budget);
        int k = 0;
        while (ctl_req !== 1'b1 && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("ctl_req_wait_bound", 64'(ctl_req), 64'd1);
    endtask

    // Controller model: lat > 0 answers on the lat-th WAIT cycle, lat <= 0
    // never answers.
    initial begin
        forever begin
            @(negedge clock);
            if (ctl_req === 1'b1) begin
                n_ctlreq++;
                req_cyc = cyc;
                if (lat > 0) begin
                    repeat (lat) @(negedge clock);
                    m_done   = 1'b1;
                    m_rdata  = resp;
                    done_cyc = cyc;
                    @(negedge clock);
                    m_done   = 1'b0;
                    m_rdata  = '0;
                end
            end
        end
    end

    // Monitor: every ack pops one expected entry.
    always @(negedge clock) begin
        if (a_ack || b_ack) begin
            n_acks++;
            if (sb.size() == 0) begin
                check("unexpected_ack", {62'd0, a_ack, b_ack}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_port", {62'd0, a_ack, b_ack},
                      mon_e.port_b ? 64'd1 : 64'd2);
                check("ack_rdata", 64'(rdata), 64'(mon_e.data));
                check("ack_timeout", 64'(timeout), 64'(mon_e.tmo));
                if (mon_e.wdog)
                    check("wdog_latency", 64'(cyc - req_cyc), 64'd256);
                else
                    check("ack_latency", 64'(cyc - done_cyc), 64'd1);
            end
        end
    end

    initial begin
        int viol;

        // Reset state
        repeat (3) @(negedge clock);
        check_zero("reset_state");
        reset = 1'b0;

        // Ready gating, then single read of 0x000123 returning 0xBEEF
        a_req  = 1'b1;
        a_we   = 1'b0;
        a_addr = 24'h000123;
        lat    = 3;
        resp   = 16'hBEEF;
        viol   = 0;
        repeat (20) begin
            @(negedge clock);
            if (ctl_req || a_gnt || b_gnt) viol++;
        end
        check("ready_gating", 64'(viol), 64'd0);
        push_exp(1'b0, 16'hBEEF, 1'b0, 1'b0);
        ctl_ready = 1'b1;
        @(negedge clock);
        check("req_after_ready", {61'd0, ctl_req, a_gnt, b_gnt}, 64'b110);
        check("read_issue_we", 64'(ctl_we), 64'd0);
        check("read_issue_addr", 64'(ctl_addr), 64'h000123);
        wait_acks(1, 50);
        a_req = 1'b0;
        repeat (3) @(negedge clock);
        check("read_req_pulses", 64'(n_ctlreq), 64'd1);

        // Single write on B: 0x5A5A to 0xFFFFFF
        b_req   = 1'b1;
        b_we    = 1'b1;
        b_addr  = 24'hFFFFFF;
        b_wdata = 16'h5A5A;
        lat     = 2;
        resp    = 16'h0000;
        push_exp(1'b1, 16'h0000, 1'b0, 1'b0);
        wait_ctl_req(20);
        check("write_issue_we", 64'(ctl_we), 64'd1);
        check("write_issue_addr", 64'(ctl_addr), 64'hFFFFFF);
        check("write_issue_wdata", 64'(ctl_wdata), 64'h5A5A);
        check("write_issue_gnt", {62'd0, a_gnt, b_gnt}, 64'b01);
        wait_acks(2, 50);
        b_req = 1'b0;
        b_we  = 1'b0;
        repeat (3) @(negedge clock);

        // Contention: both held for four accesses
        a_addr = 24'h0000AA;
        b_addr = 24'h0000BB;
        lat    = 1;
        resp   = 16'hC0DE;
`ifdef SDRAM_ARB_RR_EN
        push_exp(1'b0, 16'hC0DE, 1'b0, 1'b0);
        push_exp(1'b1, 16'hC0DE, 1'b0, 1'b0);
        push_exp(1'b0, 16'hC0DE, 1'b0, 1'b0);
        push_exp(1'b1, 16'hC0DE, 1'b0, 1'b0);
`else
        for (int i = 0; i < 4; i++) push_exp(1'b0, 16'hC0DE, 1'b0, 1'b0);
`endif
        a_req = 1'b1;
        b_req = 1'b1;
        wait_acks(6, 200);
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (4) @(negedge clock);

        // Watchdog: controller never answers
        lat    = -1;
        a_addr = 24'h000042;
        push_exp(1'b0, 16'h0000, 1'b1, 1'b1);
        a_req  = 1'b1;
        wait_acks(7, 400);
        a_req = 1'b0;
        repeat (3) @(negedge clock);
        check("timeout_sticky", 64'(timeout), 64'd1);

        // Next access still succeeds, timeout stays set
        lat    = 2;
        resp   = 16'h1234;
        b_addr = 24'h000010;
        push_exp(1'b1, 16'h1234, 1'b1, 1'b0);
        b_req  = 1'b1;
        wait_acks(8, 50);
        b_req = 1'b0;
        repeat (3) @(negedge clock);

        // Reset in WAIT, then a late ctl_done
        lat    = -1;
        a_addr = 24'h000055;
        a_req  = 1'b1;
        wait_ctl_req(20);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        a_req = 1'b0;
        @(negedge clock);
        check_zero("mid_access_reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        s_done  = 1'b1;
        s_rdata = 16'hDEAD;
        @(negedge clock);
        s_done  = 1'b0;
        s_rdata = '0;
        repeat (5) @(negedge clock);
        check("late_done_no_ack", 64'(n_acks), 64'd8);
        check("late_done_idle", {60'd0, ctl_req, a_gnt, b_gnt, timeout}, 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
